// File: rtl/wr_chan_arbiter.sv
// Write-burst scheduler: picks a channel whose FIFO holds a full burst, issues one
// AXI burst command for it and advances that channel's wrapping address pointer.
module wr_chan_arbiter #(
  parameter int CH_NUM     = 4,
  parameter int CH_ID_W    = 2,
  parameter int ADDR_WIDTH = 30,
  parameter int AXI_WIDTH  = 64,
  parameter int BB_L2      = 3,
  parameter int CNT_WIDTH  = 12,
  parameter int RR_MODE    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CH_NUM-1:0]            chan_en,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] chan_beg_addr,
  input  logic [CH_NUM*ADDR_WIDTH-1:0] chan_end_addr,
  input  logic [CH_NUM*8-1:0]          chan_burst_len,
  input  logic [CH_NUM*CNT_WIDTH-1:0]  chan_fifo_cnt,
  input  logic [CH_NUM-1:0]            chan_addr_clr,
  output logic                         cmd_valid,
  input  logic                         cmd_ready,
  output logic [ADDR_WIDTH-1:0]        cmd_addr,
  output logic [7:0]                   cmd_len,
  output logic [CH_ID_W-1:0]           cmd_id,
  input  logic                         burst_done,
  output logic                         busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_UPD  = 2'd3;

  localparam int BEAT_SHIFT = ((AXI_WIDTH / 8) == (1 << BB_L2)) ? BB_L2 : $clog2(AXI_WIDTH / 8);
  localparam int XW         = ADDR_WIDTH + 2;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] ptr   [CH_NUM];
  logic [ADDR_WIDTH-1:0] beg_a [CH_NUM];
  logic [ADDR_WIDTH-1:0] end_a [CH_NUM];
  logic [7:0]            len_a [CH_NUM];
  logic [CH_NUM-1:0]     req;
  logic [CH_ID_W-1:0]    rr_base;
  logic [CH_ID_W-1:0]    rr_next;
  logic [CH_ID_W-1:0]    gnt_idx;
  logic                  gnt_any;

  logic [XW-1:0]         bytes_lat;
  logic [XW-1:0]         bytes_cur;
  logic [XW-1:0]         nxt_addr;
  logic [XW-1:0]         last_addr;
  logic                  wrap;
  logic [ADDR_WIDTH-1:0] upd_ptr;

  // Fill-level compare is widened by one bit so len 255 never overflows the threshold.
  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_chan
    logic [CNT_WIDTH:0] cnt_x;
    logic [CNT_WIDTH:0] need_x;

    assign beg_a[gi] = chan_beg_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign end_a[gi] = chan_end_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign len_a[gi] = chan_burst_len[gi*8 +: 8];
    assign cnt_x     = {1'b0, chan_fifo_cnt[gi*CNT_WIDTH +: CNT_WIDTH]};
    assign need_x    = (CNT_WIDTH+1)'(chan_burst_len[gi*8 +: 8]) + (CNT_WIDTH+1)'(1);
    assign req[gi]   = chan_en[gi] & (cnt_x >= need_x);
  end

  always_comb begin
    int idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (RR_MODE != 0) idx = (int'(rr_base) + k) % CH_NUM;
      else              idx = k;
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = CH_ID_W'(idx);
      end
    end
  end

  // Advance uses the len latched at grant; the fit test against the region end uses the live len.
  always_comb begin
    bytes_lat = (XW'(cmd_len) + XW'(1)) << BEAT_SHIFT;
    bytes_cur = (XW'(len_a[cmd_id]) + XW'(1)) << BEAT_SHIFT;
    nxt_addr  = XW'(ptr[cmd_id]) + bytes_lat;
    last_addr = nxt_addr + bytes_cur - XW'(1);
    wrap      = last_addr > XW'(end_a[cmd_id]);
    upd_ptr   = wrap ? beg_a[cmd_id] : nxt_addr[ADDR_WIDTH-1:0];
    rr_next   = (cmd_id == CH_ID_W'(CH_NUM - 1)) ? '0 : cmd_id + CH_ID_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cmd_addr <= '0;
      cmd_len  <= '0;
      cmd_id   <= '0;
      rr_base  <= '0;
      for (int i = 0; i < CH_NUM; i++) ptr[i] <= beg_a[i];
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            cmd_id   <= gnt_idx;
            cmd_addr <= ptr[gnt_idx];
            cmd_len  <= len_a[gnt_idx];
            state    <= ST_CMD;
          end
        end
        ST_CMD:  if (cmd_ready)  state <= ST_WAIT;
        ST_WAIT: if (burst_done) state <= ST_UPD;
        ST_UPD: begin
          if (RR_MODE != 0) rr_base <= rr_next;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A clear pulse beats the post-burst update of the same channel.
      for (int i = 0; i < CH_NUM; i++) begin
        if (chan_addr_clr[i])                                ptr[i] <= beg_a[i];
        else if (state == ST_UPD && cmd_id == CH_ID_W'(i))   ptr[i] <= upd_ptr;
      end
    end
  end

  assign cmd_valid = (state == ST_CMD);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_wr_chan_arbiter.sv
// Self-checking bench for wr_chan_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_wr_chan_arbiter;

  localparam int N  = 4;
  localparam int AW = 30;
  localparam int CW = 12;
  localparam int PH_IDLE = 0;
  localparam int PH_CMD  = 1;
  localparam int PH_WAIT = 2;
  localparam int PH_UPD  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    chan_en;
  logic [N-1:0]    chan_addr_clr;
  logic [N*AW-1:0] beg_flat;
  logic [N*AW-1:0] end_flat;
  logic [N*8-1:0]  len_flat;
  logic [N*CW-1:0] rr_cnt;
  logic [N*CW-1:0] fx_cnt;
  logic            cmd_ready;
  logic            burst_done;

  logic            rr_valid, rr_busy, fx_valid, fx_busy;
  logic [AW-1:0]   rr_addr, fx_addr;
  logic [7:0]      rr_len, fx_len;
  logic [1:0]      rr_id, fx_id;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wr_chan_arbiter #(.RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .chan_en(chan_en), .chan_beg_addr(beg_flat),
    .chan_end_addr(end_flat), .chan_burst_len(len_flat), .chan_fifo_cnt(rr_cnt),
    .chan_addr_clr(chan_addr_clr), .cmd_valid(rr_valid), .cmd_ready(cmd_ready),
    .cmd_addr(rr_addr), .cmd_len(rr_len), .cmd_id(rr_id), .burst_done(burst_done),
    .busy(rr_busy)
  );

  wr_chan_arbiter #(.RR_MODE(0)) u_fx (
    .clk(clk), .rst(rst), .chan_en(chan_en), .chan_beg_addr(beg_flat),
    .chan_end_addr(end_flat), .chan_burst_len(len_flat), .chan_fifo_cnt(fx_cnt),
    .chan_addr_clr(chan_addr_clr), .cmd_valid(fx_valid), .cmd_ready(cmd_ready),
    .cmd_addr(fx_addr), .cmd_len(fx_len), .cmd_id(fx_id), .burst_done(burst_done),
    .busy(fx_busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input longint exp);
    n_checks++;
    if (act !== 64'(exp)) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("[TB] FAIL %s: got timeout expected cmd_valid", name);
  endtask

  function automatic longint beg_of(input int i);
    return longint'(beg_flat[i*AW +: AW]);
  endfunction
  function automatic longint end_of(input int i);
    return longint'(end_flat[i*AW +: AW]);
  endfunction
  function automatic longint len_of(input int i);
    return longint'(len_flat[i*8 +: 8]);
  endfunction
  function automatic longint cnt_of(input int i);
    return longint'(rr_cnt[i*CW +: CW]);
  endfunction

  // Reference model of the round-robin instance, evaluated from the rules with plain arithmetic.
  bit     m_live = 1'b0;
  int     m_phase = PH_IDLE;
  int     m_id = 0;
  longint m_addr = 0;
  longint m_len = 0;
  int     m_base = 0;
  longint mptr [N];

  always @(posedge clk) begin
    int     g;
    bit     any;
    longint nxt;
    if (rst) begin
      m_live  = 1'b1;
      m_phase = PH_IDLE;
      m_id    = 0;
      m_addr  = 0;
      m_len   = 0;
      m_base  = 0;
      for (int i = 0; i < N; i++) mptr[i] = beg_of(i);
    end else if (m_live) begin
      case (m_phase)
        PH_IDLE: begin
          any = 1'b0;
          g   = 0;
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_base + k) % N;
            if (!any && chan_en[c] && cnt_of(c) >= len_of(c) + 1) begin
              any = 1'b1;
              g   = c;
            end
          end
          if (any) begin
            m_id    = g;
            m_addr  = mptr[g];
            m_len   = len_of(g);
            m_phase = PH_CMD;
          end
        end
        PH_CMD:  if (cmd_ready)  m_phase = PH_WAIT;
        PH_WAIT: if (burst_done) m_phase = PH_UPD;
        default: begin
          nxt = mptr[m_id] + (m_len + 1) * 8;
          if (nxt + (len_of(m_id) + 1) * 8 - 1 > end_of(m_id)) mptr[m_id] = beg_of(m_id);
          else                                                mptr[m_id] = nxt;
          m_base  = (m_id + 1) % N;
          m_phase = PH_IDLE;
        end
      endcase
      for (int i = 0; i < N; i++) if (chan_addr_clr[i]) mptr[i] = beg_of(i);
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      checkOutput("model_valid", rr_valid, (m_phase == PH_CMD) ? 1 : 0);
      checkOutput("model_busy",  rr_busy,  (m_phase != PH_IDLE) ? 1 : 0);
      checkOutput("model_addr",  rr_addr,  m_addr);
      checkOutput("model_len",   rr_len,   m_len);
      checkOutput("model_id",    rr_id,    m_id);
    end
  end

  task automatic set_chan(input int ch, input longint b, input longint e, input int l);
    beg_flat[ch*AW +: AW] = AW'(b);
    end_flat[ch*AW +: AW] = AW'(e);
    len_flat[ch*8 +: 8]   = 8'(l);
  endtask

  task automatic set_cnt(input bit fx, input int ch, input int v);
    if (fx) fx_cnt[ch*CW +: CW] = CW'(v);
    else    rr_cnt[ch*CW +: CW] = CW'(v);
  endtask

  task automatic do_reset();
    cmd_ready     = 1'b0;
    burst_done    = 1'b0;
    chan_addr_clr = '0;
    rst           = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_valid(input bit fx, output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      seen = fx ? fx_valid : rr_valid;
    end
  endtask

  // Waits for a command, checks it, optionally stalls ready, then acks and completes it.
  task automatic do_burst(input bit fx, input int exp_id, input longint exp_addr, input int exp_len,
                          input int hold, input logic [N-1:0] upd_clr, input string tag);
    bit seen;
    wait_valid(fx, seen);
    if (!seen) begin
      fail_now({tag, "_timeout"});
      return;
    end
    checkOutput({tag, "_id"},   fx ? fx_id   : rr_id,   exp_id);
    checkOutput({tag, "_addr"}, fx ? fx_addr : rr_addr, exp_addr);
    checkOutput({tag, "_len"},  fx ? fx_len  : rr_len,  exp_len);
    if (!fx) checkOutput({tag, "_model_addr"}, 64'(m_addr), exp_addr);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checkOutput({tag, "_hold_valid"}, fx ? fx_valid : rr_valid, 1);
      checkOutput({tag, "_hold_addr"},  fx ? fx_addr  : rr_addr,  exp_addr);
      checkOutput({tag, "_hold_len"},   fx ? fx_len   : rr_len,   exp_len);
    end
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    burst_done = 1'b1;
    @(posedge clk);
    #1 burst_done = 1'b0;
    chan_addr_clr = upd_clr;
    @(posedge clk);
    #1 chan_addr_clr = '0;
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      rr_cnt[i*CW +: CW] = CW'($urandom_range(0, 20));
      chan_en[i]         = ($urandom_range(0, 9) != 0);
      chan_addr_clr[i]   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) len_flat[i*8 +: 8] = 8'($urandom_range(0, 15));
    end
    cmd_ready  = ($urandom_range(0, 1) == 1);
    burst_done = ($urandom_range(0, 2) == 0);
    rst        = ($urandom_range(0, 399) == 0);
  endtask

  int     rr_ids   [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
  longint rr_addrs [8] = '{0, 1024, 2048, 3072, 64, 1056, 2064, 3080};
  int     rr_lens  [8] = '{7, 3, 1, 0, 7, 3, 1, 0};

  initial begin
    bit seen;
    rst = 1'b1;
    chan_en = '1;
    chan_addr_clr = '0;
    cmd_ready = 1'b0;
    burst_done = 1'b0;
    rr_cnt = '0;
    fx_cnt = '0;
    beg_flat = '0;
    end_flat = '0;
    len_flat = '0;
    set_chan(0, 0,    1023, 7);
    set_chan(1, 1024, 2047, 3);
    set_chan(2, 2048, 3071, 1);
    set_chan(3, 3072, 4095, 0);

    do_reset();
    @(negedge clk);
    checkOutput("rst_valid", rr_valid, 0);
    checkOutput("rst_busy",  rr_busy,  0);
    checkOutput("rst_addr",  rr_addr,  0);
    checkOutput("rst_len",   rr_len,   0);
    checkOutput("rst_id",    rr_id,    0);
    checkOutput("rst_fx_busy", fx_busy, 0);

    $display("[TB] single channel lap");
    set_cnt(0, 0, 8);
    for (int k = 0; k < 17; k++) do_burst(0, 0, (k * 64) % 1024, 7, 0, '0, "lap");
    set_cnt(0, 0, 0);

    $display("[TB] round-robin fairness");
    do_reset();
    set_cnt(0, 0, 8);
    set_cnt(0, 1, 4);
    set_cnt(0, 2, 2);
    set_cnt(0, 3, 1);
    for (int k = 0; k < 8; k++) do_burst(0, rr_ids[k], rr_addrs[k], rr_lens[k], 0, '0, "rr");
    rr_cnt = '0;

    $display("[TB] request threshold");
    do_reset();
    repeat (3) @(negedge clk);
    checkOutput("thr_cnt0_valid", rr_valid, 0);
    @(posedge clk);
    #1 set_cnt(0, 3, 1);
    @(negedge clk);
    checkOutput("thr_before_valid", rr_valid, 0);
    @(negedge clk);
    checkOutput("thr_latency_valid", rr_valid, 1);
    set_cnt(0, 3, 0);
    do_burst(0, 3, 3072, 0, 0, '0, "thr_ch3");
    set_cnt(0, 0, 7);
    repeat (6) @(negedge clk);
    checkOutput("thr_cnt7_valid", rr_valid, 0);
    checkOutput("thr_cnt7_busy",  rr_busy,  0);
    set_cnt(0, 0, 8);
    do_burst(0, 0, 0, 7, 0, '0, "thr_cnt8");
    set_cnt(0, 0, 0);

    $display("[TB] handshake stall and clear on update");
    do_reset();
    set_cnt(0, 0, 8);
    do_burst(0, 0, 0, 7, 5, '0, "hs");
    for (int k = 1; k < 6; k++) do_burst(0, 0, k * 64, 7, 0, (k == 5) ? 4'b0001 : 4'b0000, "clr_seq");
    do_burst(0, 0, 0, 7, 0, '0, "clr_next");
    set_cnt(0, 0, 0);

    $display("[TB] reset during wait");
    do_reset();
    set_cnt(0, 0, 8);
    do_burst(0, 0, 0, 7, 0, '0, "rw_first");
    wait_valid(0, seen);
    if (!seen) fail_now("rw_second_timeout");
    checkOutput("rw_second_addr", rr_addr, 64);
    cmd_ready = 1'b1;
    @(posedge clk);
    #1 cmd_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rw_busy",  rr_busy,  0);
    checkOutput("rw_valid", rr_valid, 0);
    do_burst(0, 0, 0, 7, 0, '0, "rw_after");
    set_cnt(0, 0, 0);

    $display("[TB] fixed priority");
    do_reset();
    set_cnt(1, 0, 8);
    set_cnt(1, 2, 2);
    for (int k = 0; k < 5; k++) do_burst(1, 0, k * 64, 7, 0, '0, "fx_starve");
    set_cnt(1, 0, 7);
    do_burst(1, 2, 2048, 1, 0, '0, "fx_ch2");
    fx_cnt = '0;

    $display("[TB] randomized traffic");
    do_reset();
    set_chan(3, 3072, 3271, 0);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1 applyStimulus();
    end
    @(posedge clk);
    #1 rst = 1'b0;
    cmd_ready = 1'b0;
    burst_done = 1'b0;
    chan_addr_clr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wr_chan_arbiter.md
# wr_chan_arbiter

N-channel write-burst scheduler between the per-channel write FIFOs and the single AXI write master. It keeps one address pointer per channel and watches each channel's FIFO fill level. When a channel holds enough words for one burst, it grants that channel (round-robin or fixed priority) and issues one burst command (address, length, channel id) to the AXI master. It advances that channel's pointer only after the burst completes, and wraps the pointer inside the channel's `[beg, end]` region. This generalises the fixed 4-channel write interface to `CH_NUM` channels with a selectable arbitration mode and per-channel pointer clear.

## Interface
Parameters:
- `CH_NUM`, 4: number of write channels (2..16).
- `CH_ID_W`, 2: width of the channel id, = clog2(`CH_NUM`).
- `ADDR_WIDTH`, 30: byte-address width.
- `AXI_WIDTH`, 64: AXI data width in bits; beat size `BB` = `AXI_WIDTH`/8 bytes.
- `BB_L2`, 3: log2(`BB`).
- `CNT_WIDTH`, 12: width of each FIFO fill count, counted in AXI words.
- `RR_MODE`, 1: 1 = round-robin, 0 = fixed priority (channel 0 highest).

Ports:
- `clk` in 1: single clock, shared with the AXI master.
- `rst` in 1: synchronous, active-high reset.
- `chan_en` in `CH_NUM`: per-channel enable; a disabled channel never requests.
- `chan_beg_addr` in `CH_NUM`*`ADDR_WIDTH`: per-channel region start (byte address), flattened with channel i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `chan_end_addr` in `CH_NUM`*`ADDR_WIDTH`: per-channel region end (inclusive).
- `chan_burst_len` in `CH_NUM`*8: AXI len per channel, i.e. beats − 1.
- `chan_fifo_cnt` in `CH_NUM`*`CNT_WIDTH`: words currently readable in each write FIFO.
- `chan_addr_clr` in `CH_NUM`: one-cycle pulse that returns that channel's pointer to its beg_addr.
- `cmd_valid` out 1: burst command valid.
- `cmd_ready` in 1: AXI master accepts the command.
- `cmd_addr` out `ADDR_WIDTH`: burst start address.
- `cmd_len` out 8: burst len.
- `cmd_id` out `CH_ID_W`: granted channel; also selects the FIFO read mux.
- `burst_done` in 1: one-cycle pulse from the AXI master when the B response for the current burst is accepted.
- `busy` out 1: high in every state except IDLE.

## Operation
- Request: `req[i]` = `chan_en[i]` & (`chan_fifo_cnt[i]` ≥ `chan_burst_len[i]` + 1). The comparison is done at `CNT_WIDTH`+1 bits.
- State machine:
  - IDLE: if `req` ≠ 0, latch the granted index `g`, `cmd_addr` = `ptr[g]` and `cmd_len` = `len[g]`; go to CMD.
  - CMD: `cmd_valid` = 1; on `cmd_ready`, go to WAIT.
  - WAIT: on `burst_done`, go to UPD.
  - UPD: update `ptr[g]`; in RR mode set `rr_base` = `g`+1 mod `CH_NUM`; go to IDLE.
- Grant rules:
  - RR mode: the first requesting channel searching upward from `rr_base`, wrapping around.
  - Fixed mode: the lowest requesting index.
  - `rr_base` resets to 0.
- Pointer update:
  - `bytes` = (`len[g]`+1) << `BB_L2`, using the len latched at grant.
  - `nxt` = `ptr[g]` + `bytes`, computed at `ADDR_WIDTH`+1 bits.
  - If `nxt` + `bytes` − 1 > `chan_end_addr[g]`, then `ptr[g]` ← `beg_addr[g]`; otherwise `ptr[g]` ← `nxt`.
  - The test uses the current `chan_burst_len[g]` for `bytes`.
- Clear: `chan_addr_clr[i]` loads `ptr[i]` ← `beg_addr[i]` in that cycle.
  - If the clear coincides with UPD for the same channel, the clear wins.
  - A clear during CMD/WAIT of the granted channel does not change the already latched `cmd_addr`.
- `cmd_addr`, `cmd_len` and `cmd_id` are registered and held stable from CMD entry until the next grant.
- Input changes to the len/beg/end of a channel are ignored while that channel is granted, except in the wrap test above.

## Timing
- Reset values: `cmd_valid` 0, `cmd_addr` 0, `cmd_len` 0, `cmd_id` 0, `busy` 0, state IDLE, `ptr[i]` = `beg_addr[i]` (sampled during reset), `rr_base` 0.
- Latency: `req` seen in IDLE at cycle t gives `cmd_valid` = 1 at t+1.
- After `burst_done` at cycle t: UPD at t+1, IDLE at t+2, earliest next `cmd_valid` at t+3.
- `cmd_valid` stays high, with stable fields, until the cycle `cmd_ready` = 1; it deasserts the following cycle.
- `cmd_ready` while not in CMD is ignored. `burst_done` outside WAIT is ignored.
- `rst` asserted mid-burst (any state) returns everything to reset values in the next cycle. No completion is waited for.
- `req` dropping during CMD/WAIT does not cancel the command.

## Test plan
- Defaults, beats 8 B. Ch0: beg 0, end 1023, len 7 (64 B), FIFO count held at 8; slave acks immediately. Expect `cmd_addr` 0, 64, …, 960, then 0 again (16 bursts per lap), `cmd_id` 0, `cmd_len` 7 each time.
- RR fairness. All four channels requesting; ch1..3 use beg 1024/2048/3072 with len 3/1/0. Expect grants in order 0,1,2,3,0, … and first addresses 0, 1024, 2048, 3072. Then ch1's second address is 1056 and ch2's is 2064.
- Fixed mode (`RR_MODE` 0). Ch0 and ch2 requesting continuously. Expect `cmd_id` always 0 and ch2 starved. Dropping ch0's count to 7 gives the next grant to ch2.
- Threshold. Ch3 len 0 with count 0 issues no cmd. Count 1 gives `cmd_valid` exactly one cycle later. Ch0 len 7 with count 7 issues no cmd; count 8 issues one.
- Handshake and clear. Hold `cmd_ready` low for 5 cycles: `cmd_valid` and its fields stay stable. Pulse `chan_addr_clr[0]` in the same cycle as UPD after the burst at 320: the next ch0 address is 0, not 384.
- Reset mid-WAIT. Assert `rst` for 1 cycle during WAIT: `busy` and `cmd_valid` read 0 the next cycle, pointers return to beg, and the first grant afterwards is ch0 at addr 0.
